// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store port and the CRAS spill/fill port.
// Core has fixed priority; CRAS is forced through after STARVE_MAX consecutive losses.
module dmem_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_valid,
  output logic        core_hold,
  input  logic        ras_rd,
  input  logic        ras_wr,
  input  logic [31:0] ras_addr,
  input  logic [31:0] ras_din,
  output logic [31:0] ras_dout,
  output logic        ras_rdy,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  state_t     state;
  logic [3:0] starve;
  logic       owner;
  logic       is_wr;
  logic [1:0] wcnt;

  logic cras_req;
  logic grant_cras;
  logic grant_core;

  assign cras_req   = ras_rd | ras_wr;
  assign grant_cras = cras_req & (~core_req | (starve == SMAX));
  assign grant_core = core_req & ~grant_cras;

  // owner 0 = core, 1 = CRAS
  assign core_hold = core_req & ~((state == DONE) & ~owner);

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      starve     <= '0;
      owner      <= 1'b0;
      is_wr      <= 1'b0;
      wcnt       <= '0;
      core_rdata <= '0;
      core_valid <= 1'b0;
      ras_dout   <= '0;
      ras_rdy    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      core_valid <= 1'b0;
      ras_rdy    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_cras) begin
            owner     <= 1'b1;
            is_wr     <= ras_wr;
            mem_addr  <= ras_addr;
            mem_wdata <= ras_din;
            mem_we    <= ras_wr ? 4'hF : 4'h0;
            mem_en    <= 1'b1;
            starve    <= '0;
            state     <= ACC;
          end else if (grant_core) begin
            owner     <= 1'b0;
            is_wr     <= core_we;
            mem_addr  <= core_addr;
            mem_wdata <= core_wdata;
            mem_we    <= core_we ? core_be : 4'h0;
            mem_en    <= 1'b1;
            state     <= ACC;
            if (cras_req && starve != SMAX)
              starve <= starve + 4'd1;
          end
        end
        ACC: begin
          mem_en <= 1'b0;
          mem_we <= '0;
          wcnt   <= '0;
          if (is_wr) begin
            core_valid <= ~owner;
            ras_rdy    <= owner;
            state      <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == LAST) begin
            if (owner) ras_dout <= mem_rdata;
            else core_rdata <= mem_rdata;
            core_valid <= ~owner;
            ras_rdy    <= owner;
            state      <= DONE;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: u0 runs RD_LAT=1, u1 runs RD_LAT=3.
// Both share stimulus; each has its own latency-accurate memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic        ras_rd, ras_wr;
  logic [31:0] ras_addr, ras_din;

  logic [31:0] core_rdata0, ras_dout0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        core_valid0, core_hold0, ras_rdy0, mem_en0;
  logic [3:0]  mem_we0;
  logic [31:0] core_rdata1, ras_dout1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        core_valid1, core_hold1, ras_rdy1, mem_en1;
  logic [3:0]  mem_we1;
  logic [31:0] p1, p2;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u0 (
    .clk(clk), .Rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata0), .core_valid(core_valid0), .core_hold(core_hold0),
    .ras_rd(ras_rd), .ras_wr(ras_wr), .ras_addr(ras_addr), .ras_din(ras_din),
    .ras_dout(ras_dout0), .ras_rdy(ras_rdy0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  dmem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u1 (
    .clk(clk), .Rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata1), .core_valid(core_valid1), .core_hold(core_hold1),
    .ras_rd(ras_rd), .ras_wr(ras_wr), .ras_addr(ras_addr), .ras_din(ras_din),
    .ras_dout(ras_dout1), .ras_rdy(ras_rdy1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h40:  return 32'hDEADBEEF;
      32'h10:  return 32'h5A5A0010;
      default: return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  // Data is valid only exactly RD_LAT cycles after mem_en; garbage otherwise
  always @(posedge clk) begin
    mem_rdata0 <= mem_en0 ? rom(mem_addr0) : 32'hBAD0BAD0;
    p1         <= mem_en1 ? rom(mem_addr1) : 32'hBAD0BAD0;
    p2         <= p1;
    mem_rdata1 <= p2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_be = 4'h0;
    core_addr = '0; core_wdata = '0;
    ras_rd = 1'b0; ras_wr = 1'b0; ras_addr = '0; ras_din = '0;
    nxt(); nxt(); #1;
    chk("rst_rdata", core_rdata0, 0);
    chk("rst_valid", {31'd0, core_valid0}, 0);
    chk("rst_dout", ras_dout0, 0);
    chk("rst_rdy", {31'd0, ras_rdy0}, 0);
    chk("rst_en", {31'd0, mem_en0}, 0);
    chk("rst_we", {28'd0, mem_we0}, 0);
    chk("rst_addr", mem_addr0, 0);
    chk("rst_wdata", mem_wdata0, 0);
    chk("rst_starve", {28'd0, u0.starve}, 0);
    rst_n = 1'b1;

    // core read 0x40
    nxt(); core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; #1;
    chk("t1_hold_c0", {31'd0, core_hold0}, 1);
    chk("t1_en_c0", {31'd0, mem_en0}, 0);
    nxt(); #1;
    chk("t1_en_c1", {31'd0, mem_en0}, 1);
    chk("t1_addr_c1", mem_addr0, 32'h40);
    chk("t1_we_c1", {28'd0, mem_we0}, 0);
    chk("t1_hold_c1", {31'd0, core_hold0}, 1);
    nxt(); #1;
    chk("t1_en_c2", {31'd0, mem_en0}, 0);
    chk("t1_valid_c2", {31'd0, core_valid0}, 0);
    chk("t1_hold_c2", {31'd0, core_hold0}, 1);
    nxt(); #1;
    chk("t1_valid_c3", {31'd0, core_valid0}, 1);
    chk("t1_rdata_c3", core_rdata0, 32'hDEADBEEF);
    chk("t1_hold_c3", {31'd0, core_hold0}, 0);
    core_req = 1'b0;
    nxt(); #1;
    chk("t1_valid_c4", {31'd0, core_valid0}, 0);
    chk("t1_rdata_c4", core_rdata0, 32'hDEADBEEF);

    // core write, be=0011
    nxt(); core_req = 1'b1; core_we = 1'b1; core_be = 4'b0011;
    core_addr = 32'h44; core_wdata = 32'h12345678; #1;
    nxt(); #1;
    chk("t2_en_c1", {31'd0, mem_en0}, 1);
    chk("t2_we_c1", {28'd0, mem_we0}, 4'b0011);
    chk("t2_wdata_c1", mem_wdata0, 32'h12345678);
    chk("t2_addr_c1", mem_addr0, 32'h44);
    nxt(); #1;
    chk("t2_valid_c2", {31'd0, core_valid0}, 1);
    chk("t2_rdata_c2", core_rdata0, 32'hDEADBEEF);
    chk("t2_we_c2", {28'd0, mem_we0}, 0);
    core_req = 1'b0;
    nxt(); #1;
    chk("t2_valid_c3", {31'd0, core_valid0}, 0);

    // core read and CRAS write in the same IDLE cycle
    nxt(); core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    ras_wr = 1'b1; ras_addr = 32'h80; ras_din = 32'hCAFEF00D; #1;
    nxt(); #1;
    chk("t3_addr_c1", mem_addr0, 32'h40);
    chk("t3_starve_c1", {28'd0, u0.starve}, 1);
    nxt(); #1;
    nxt(); #1;
    chk("t3_cvalid_c3", {31'd0, core_valid0}, 1);
    core_req = 1'b0;
    nxt(); #1;
    chk("t3_en_c4", {31'd0, mem_en0}, 0);
    nxt(); #1;
    chk("t3_en_c5", {31'd0, mem_en0}, 1);
    chk("t3_we_c5", {28'd0, mem_we0}, 4'hF);
    chk("t3_addr_c5", mem_addr0, 32'h80);
    chk("t3_wdata_c5", mem_wdata0, 32'hCAFEF00D);
    chk("t3_starve_c5", {28'd0, u0.starve}, 0);
    nxt(); #1;
    chk("t3_rdy_c6", {31'd0, ras_rdy0}, 1);
    ras_wr = 1'b0;
    nxt(); #1;
    chk("t3_rdy_c7", {31'd0, ras_rdy0}, 0);

    // starvation: 4 core reads, forced CRAS read, then core again
    for (int c = 0; c < 24; c++) begin
      nxt();
      if (c == 0) begin
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
        ras_rd = 1'b1; ras_addr = 32'h10;
      end
      #1;
      chk($sformatf("t4_en_c%0d", c), {31'd0, mem_en0}, {31'd0, (c % 4) == 1});
      if ((c % 4) == 1)
        chk($sformatf("t4_addr_c%0d", c), mem_addr0, (c == 17) ? 32'h10 : 32'h40);
      chk($sformatf("t4_cvalid_c%0d", c), {31'd0, core_valid0},
          {31'd0, ((c % 4) == 3) && (c != 19)});
      chk($sformatf("t4_rdy_c%0d", c), {31'd0, ras_rdy0}, {31'd0, c == 19});
      chk($sformatf("t4_hold_c%0d", c), {31'd0, core_hold0},
          {31'd0, !(((c % 4) == 3) && (c != 19))});
      if (c == 16) chk("t4_starve_c16", {28'd0, u0.starve}, 4);
      if (c == 19) begin
        chk("t4_dout_c19", ras_dout0, 32'h5A5A0010);
        ras_rd = 1'b0;
      end
      if (c == 23) core_req = 1'b0;
    end

    // ras_rd and ras_wr together act as a write
    nxt(); ras_rd = 1'b1; ras_wr = 1'b1; ras_addr = 32'h84; ras_din = 32'h11223344; #1;
    nxt(); #1;
    chk("t5_we_c1", {28'd0, mem_we0}, 4'hF);
    chk("t5_wdata_c1", mem_wdata0, 32'h11223344);
    chk("t5_addr_c1", mem_addr0, 32'h84);
    nxt(); #1;
    chk("t5_rdy_c2", {31'd0, ras_rdy0}, 1);
    chk("t5_dout_c2", ras_dout0, 32'h5A5A0010);
    ras_rd = 1'b0; ras_wr = 1'b0;
    nxt(); #1;
    chk("t5_rdy_c3", {31'd0, ras_rdy0}, 0);

    // reset during WAIT of an RD_LAT=3 read (u1)
    nxt(); rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    nxt(); core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; #1;
    nxt(); #1;
    chk("t6_en_c1", {31'd0, mem_en1}, 1);
    chk("t6_addr_c1", mem_addr1, 32'h40);
    nxt(); #1;
    chk("t6_en_c2", {31'd0, mem_en1}, 0);
    nxt(); rst_n = 1'b0; core_req = 1'b0; #1;
    chk("t6_valid_c3", {31'd0, core_valid1}, 0);
    nxt(); rst_n = 1'b1; #1;
    chk("t6_rst_rdata", core_rdata1, 0);
    chk("t6_rst_valid", {31'd0, core_valid1}, 0);
    chk("t6_rst_dout", ras_dout1, 0);
    chk("t6_rst_rdy", {31'd0, ras_rdy1}, 0);
    chk("t6_rst_en", {31'd0, mem_en1}, 0);
    chk("t6_rst_we", {28'd0, mem_we1}, 0);
    chk("t6_rst_addr", mem_addr1, 0);
    chk("t6_rst_wdata", mem_wdata1, 0);
    for (int c = 5; c < 9; c++) begin
      nxt(); #1;
      chk($sformatf("t6_valid_c%0d", c), {31'd0, core_valid1}, 0);
      chk($sformatf("t6_rdata_c%0d", c), core_rdata1, 0);
    end
    nxt(); core_req = 1'b1; core_addr = 32'h48; #1;
    nxt(); #1;
    chk("t6b_en_c1", {31'd0, mem_en1}, 1);
    chk("t6b_addr_c1", mem_addr1, 32'h48);
    for (int c = 2; c < 5; c++) begin
      nxt(); #1;
      chk($sformatf("t6b_valid_c%0d", c), {31'd0, core_valid1}, 0);
    end
    nxt(); #1;
    chk("t6b_valid_c5", {31'd0, core_valid1}, 1);
    chk("t6b_rdata_c5", core_rdata1, 32'h0048C0DE);
    chk("t6b_hold_c5", {31'd0, core_hold1}, 0);
    core_req = 1'b0;
    nxt(); #1;
    chk("t6b_valid_c6", {31'd0, core_valid1}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
